project3_controller: RTL and testbench
======================================

# project3_controller

Multi-cycle control unit that sequences the Project 3 register-file/ALU datapath. It fetches 16-bit instructions over a request/valid handshake and decodes them. It drives register-file addresses, ALU operation and write-enable, and resolves a zero-test branch. It sits between instruction memory and the datapath. The datapath itself (register file, ALU) is external.

## Interface
- PC_W, 8, program-counter / instruction-address width
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high; one clock; no other clock or reset
- start  input  1  leave IDLE and begin fetching at pc=0
- instr_req  output  1  instruction fetch request
- instr_addr  output  PC_W  fetch address (= pc)
- instr_valid  input  1  instr_data valid this cycle
- instr_data  input  16  instruction word
- rf_ra  output  4  register-file read port A address
- rf_rb  output  4  register-file read port B address
- rf_wa  output  4  register-file write address
- rf_we  output  1  register-file write enable
- alu_op  output  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 PASS_A
- alu_src_imm  output  1  ALU B operand = imm instead of port B
- imm  output  4  zero-extended immediate (instr[3:0])
- alu_zero  input  1  ALU result == 0 (combinational from datapath)
- halted  output  1  HALT executed
- illegal  output  1  sticky: undefined opcode seen

## Operation
- Instruction fields: op=[15:12], rd=[11:8], rs=[7:4], rt=[3:0].
- Opcodes:
  - 0 NOP.
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR: rd <- rs op rt.
  - 6 ADDI: rd <- rs + zext(rt).
  - 7 BEQZ: if reg[rs]==0 then pc <- pc+1+sext({rd,rt}).
  - F HALT.
  - 8-E: illegal, executed as NOP with illegal set.
- States:
  - IDLE: start -> FETCH.
  - FETCH: instr_req=1, instr_addr=pc; on instr_valid latch IR -> DECODE.
  - DECODE: drive rf_ra=rs, rf_rb=rt; NOP/illegal -> FETCH with pc+1; HALT -> HALTED; else -> EXECUTE.
  - EXECUTE: alu_op/alu_src_imm valid. BEQZ samples alu_zero with alu_op=PASS_A, updates pc, -> FETCH. ALU ops -> WRITEBACK.
  - WRITEBACK: rf_we=1, rf_wa=rd, alu_op held; pc <- pc+1; -> FETCH.
  - HALTED: halted=1, terminal until reset; start ignored.
- rf_ra, rf_rb, alu_op, alu_src_imm and imm remain stable from DECODE through WRITEBACK.
- Outputs are decoded from registered state/IR (Moore); no input-to-output combinational path except through state.
- pc arithmetic is modulo 2^PC_W; increment and branch target both wrap silently.
- Register 0 is not special; writes to r0 are issued normally.

## Timing
- Reset values: state IDLE, pc=0, IR=0, and every output 0, including halted and illegal.
- Reset asserted in any state, mid-instruction included, takes effect at the next edge. rf_we is 0 in the cycle after that edge, and the in-flight instruction is abandoned.
- instr_req stays high and instr_addr stays stable until instr_valid is seen. Each extra wait cycle adds one cycle of latency. instr_valid outside FETCH is ignored.
- Latency with instr_valid in the first FETCH cycle:
  - ALU/ADDI: 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK).
  - BEQZ: 3 cycles.
  - NOP/illegal: 2 cycles.
  - HALT: 2 cycles, then HALTED.
- rf_we is high for exactly one cycle per ALU/ADDI instruction.
- start held high or pulsed is only sampled in IDLE.

## Test plan
- Reset/idle: hold reset 2 cycles with start=1 -> every output 0, state stays IDLE, instr_req low. Release reset with start=1 -> instr_req=1 and instr_addr=0 next cycle.
- ALU sequence: memory returns 0x1312 (ADD r3,r1,r2) with zero wait -> DECODE rf_ra=1, rf_rb=2; EXECUTE alu_op=000, alu_src_imm=0; WRITEBACK rf_we=1, rf_wa=3; next fetch at addr 1. Repeat with 0x6545 -> alu_src_imm=1, imm=5, rf_wa=5.
- Fetch stall: instr_valid delayed 3 cycles -> instr_req high 4 cycles, instr_addr constant, no DECODE activity early.
- Branch: at pc=0x10, 0x7F4E (offset 0xFE = -2, rs=4) with alu_zero=1 -> next fetch addr 0x0F. With alu_zero=0 -> 0x11. At pc=0xFF, offset +1 with alu_zero=1 -> wraps to 0x01.
- Illegal/halt: 0x9000 -> illegal=1 (sticky), pc+1, no rf_we. Then 0xF000 -> halted=1, instr_req=0 forever, start pulses ignored.
- Reset mid-instruction: assert reset during WRITEBACK cycle -> rf_we=0 next cycle, pc=0, IDLE, illegal/halted cleared.

Source files
------------

// File: rtl/project3_controller.sv
// project3_controller
//
// Multi-cycle control unit for the Project 3 register-file/ALU datapath.
// It fetches 16-bit instructions over a request/valid handshake and decodes
// them. It then drives the register-file addresses, the ALU operation and the
// write enable. It also resolves the BEQZ zero-test branch.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   reset        synchronous, active-high reset
//   start        leaves IDLE and begins fetching at pc=0 (only sampled in IDLE)
//   instr_req    instruction fetch request (high throughout FETCH)
//   instr_addr   fetch address, always equal to pc
//   instr_valid  instr_data is valid this cycle (only honoured in FETCH)
//   instr_data   16-bit instruction word
//   rf_ra/rf_rb  register-file read addresses (rs, rt)
//   rf_wa/rf_we  register-file write address and enable (WRITEBACK only)
//   alu_op       000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 PASS_A
//   alu_src_imm  ALU B operand comes from imm instead of read port B
//   imm          zero-extended immediate, instr[3:0]
//   alu_zero     datapath ALU result == 0
//   halted       HALT has executed; terminal until reset
//   illegal      sticky flag, an undefined opcode was decoded
//
// Instruction fields: op=[15:12], rd=[11:8], rs=[7:4], rt=[3:0].
// PC_W must be at least 8 so that the 8-bit branch offset fits.

module project3_controller #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            instr_req,
    output logic [PC_W-1:0] instr_addr,
    input  logic            instr_valid,
    input  logic [15:0]     instr_data,
    output logic [3:0]      rf_ra,
    output logic [3:0]      rf_rb,
    output logic [3:0]      rf_wa,
    output logic            rf_we,
    output logic [2:0]      alu_op,
    output logic            alu_src_imm,
    output logic [3:0]      imm,
    input  logic            alu_zero,
    output logic            halted,
    output logic            illegal
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_DECODE    = 3'd2;
    localparam logic [2:0] S_EXECUTE   = 3'd3;
    localparam logic [2:0] S_WRITEBACK = 3'd4;
    localparam logic [2:0] S_HALTED    = 3'd5;

    logic [2:0]        state;
    logic [PC_W-1:0]   pc;
    logic [15:0]       ir;
    logic              illegal_q;

    logic [3:0]        op;
    logic              is_alu;
    logic              is_beqz;
    logic              is_halt;
    logic              is_illegal;
    logic              in_dx;
    logic signed [7:0] br_off;
    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   br_target;

    assign op         = ir[15:12];
    assign is_alu     = (op >= 4'd1) && (op <= 4'd6);
    assign is_beqz    = (op == 4'd7);
    assign is_halt    = (op == 4'd15);
    assign is_illegal = (op >= 4'd8) && (op <= 4'd14);

    // The branch offset is the 8-bit value {rd,rt}. The size cast sign-extends
    // it because br_off is signed. Both sums wrap modulo 2^PC_W.
    assign br_off    = {ir[11:8], ir[3:0]};
    assign pc_inc    = pc + PC_W'(1);
    assign br_target = pc_inc + PC_W'(br_off);

    // Main sequencer. IR is captured only in FETCH, so instr_valid in any other
    // state has no effect. NOP and illegal opcodes retire straight from
    // DECODE. BEQZ is resolved in EXECUTE by sampling alu_zero while the ALU
    // passes reg[rs] through.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            pc        <= '0;
            ir        <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (instr_valid) begin
                        ir    <= instr_data;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (is_halt) begin
                        state <= S_HALTED;
                    end else if (is_alu || is_beqz) begin
                        state <= S_EXECUTE;
                    end else begin
                        pc    <= pc_inc;
                        state <= S_FETCH;
                        if (is_illegal) begin
                            illegal_q <= 1'b1;
                        end
                    end
                end
                S_EXECUTE: begin
                    if (is_beqz) begin
                        pc    <= alu_zero ? br_target : pc_inc;
                        state <= S_FETCH;
                    end else begin
                        state <= S_WRITEBACK;
                    end
                end
                S_WRITEBACK: begin
                    pc    <= pc_inc;
                    state <= S_FETCH;
                end
                S_HALTED: begin
                    state <= S_HALTED;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Moore outputs decoded from state and IR only. The datapath controls are
    // held from DECODE through WRITEBACK. They are forced to zero elsewhere,
    // so a stale IR never leaks out while idle, fetching or halted.
    always_comb begin
        in_dx       = (state == S_DECODE) || (state == S_EXECUTE) ||
                      (state == S_WRITEBACK);
        instr_req   = (state == S_FETCH);
        instr_addr  = pc;
        rf_ra       = 4'd0;
        rf_rb       = 4'd0;
        rf_wa       = 4'd0;
        rf_we       = 1'b0;
        alu_op      = 3'b000;
        alu_src_imm = 1'b0;
        imm         = 4'd0;
        halted      = (state == S_HALTED);
        illegal     = illegal_q;

        if (in_dx) begin
            rf_ra       = ir[7:4];
            rf_rb       = ir[3:0];
            imm         = ir[3:0];
            alu_src_imm = (op == 4'd6);
            case (op)
                4'd1:    alu_op = 3'b000;
                4'd2:    alu_op = 3'b001;
                4'd3:    alu_op = 3'b010;
                4'd4:    alu_op = 3'b011;
                4'd5:    alu_op = 3'b100;
                4'd6:    alu_op = 3'b000;
                4'd7:    alu_op = 3'b101;
                default: alu_op = 3'b000;
            endcase
        end

        if (state == S_WRITEBACK) begin
            rf_we = 1'b1;
            rf_wa = ir[11:8];
        end
    end

endmodule

// File: tb/tb_project3_controller.sv
// tb_project3_controller
//
// Self-checking bench for project3_controller. The bench plays the part of
// instruction memory and of the ALU zero flag. A transaction-level model
// tracks pc, illegal and halted per instruction. For each instruction the
// bench also knows which cycles the controller should spend and which
// controls it should present in each of them.

module tb_project3_controller;

    localparam int PC_W = 8;

    logic            clk;
    logic            reset;
    logic            start;
    logic            instr_req;
    logic [PC_W-1:0] instr_addr;
    logic            instr_valid;
    logic [15:0]     instr_data;
    logic [3:0]      rf_ra;
    logic [3:0]      rf_rb;
    logic [3:0]      rf_wa;
    logic            rf_we;
    logic [2:0]      alu_op;
    logic            alu_src_imm;
    logic [3:0]      imm;
    logic            alu_zero;
    logic            halted;
    logic            illegal;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_pc;
    logic       m_illegal;
    logic       m_halted;

    project3_controller #(.PC_W(PC_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .instr_req   (instr_req),
        .instr_addr  (instr_addr),
        .instr_valid (instr_valid),
        .instr_data  (instr_data),
        .rf_ra       (rf_ra),
        .rf_rb       (rf_rb),
        .rf_wa       (rf_wa),
        .rf_we       (rf_we),
        .alu_op      (alu_op),
        .alu_src_imm (alu_src_imm),
        .imm         (imm),
        .alu_zero    (alu_zero),
        .halted      (halted),
        .illegal     (illegal)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle. Outputs are sampled, and inputs are driven, 1 unit
    // after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single comparison point. It counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // ALU operation the architecture assigns to each opcode.
    function automatic logic [2:0] expAluOp(input logic [3:0] op);
        case (op)
            4'd1:    return 3'd0;
            4'd2:    return 3'd1;
            4'd3:    return 3'd2;
            4'd4:    return 3'd3;
            4'd5:    return 3'd4;
            4'd6:    return 3'd0;
            4'd7:    return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    // Runs one instruction starting in a FETCH cycle. The memory response is
    // delayed by 'waits' cycles. 'zero' is the ALU zero flag shown to a BEQZ.
    // When abort_wb is set, reset is raised during the WRITEBACK cycle.
    task automatic applyStimulus(input logic [15:0] word, input int waits,
                                 input logic zero, input logic abort_wb);
        logic [3:0] op;
        logic [3:0] rd;
        logic [3:0] rs;
        logic [3:0] rt;
        logic [7:0] off;
        logic       aborted;
        op = word[15:12];
        rd = word[11:8];
        rs = word[7:4];
        rt = word[3:0];
        off = {rd, rt};
        aborted = 1'b0;

        for (int i = 0; i < waits; i++) begin
            instr_valid = 1'b0;
            instr_data  = 16'($urandom);
            checkOutput("stall_req", instr_req, 1);
            checkOutput("stall_addr", instr_addr, m_pc);
            checkOutput("stall_we", rf_we, 0);
            checkOutput("stall_ra", rf_ra, 0);
            tick();
        end
        checkOutput("fetch_req", instr_req, 1);
        checkOutput("fetch_addr", instr_addr, m_pc);
        instr_valid = 1'b1;
        instr_data  = word;
        tick();

        // DECODE cycle: the inputs below are noise that must be ignored.
        instr_valid = 1'($urandom);
        instr_data  = 16'($urandom);
        start       = 1'($urandom);
        alu_zero    = 1'($urandom);
        checkOutput("dec_req", instr_req, 0);
        checkOutput("dec_ra", rf_ra, rs);
        checkOutput("dec_rb", rf_rb, rt);
        checkOutput("dec_we", rf_we, 0);
        if (op >= 4'd1 && op <= 4'd7) begin
            checkOutput("dec_aluop", alu_op, expAluOp(op));
            checkOutput("dec_srcimm", alu_src_imm, (op == 4'd6));
            checkOutput("dec_imm", imm, rt);
        end

        if (op == 4'd15) begin
            tick();
            m_halted = 1'b1;
        end else if (op == 4'd0 || op >= 4'd8) begin
            tick();
            m_pc = m_pc + 8'd1;
            if (op != 4'd0) m_illegal = 1'b1;
        end else if (op == 4'd7) begin
            tick();
            checkOutput("br_aluop", alu_op, 3'd5);
            checkOutput("br_ra", rf_ra, rs);
            checkOutput("br_we", rf_we, 0);
            alu_zero = zero;
            tick();
            m_pc = zero ? (m_pc + 8'd1 + off) : (m_pc + 8'd1);
        end else begin
            tick();
            checkOutput("ex_aluop", alu_op, expAluOp(op));
            checkOutput("ex_srcimm", alu_src_imm, (op == 4'd6));
            checkOutput("ex_imm", imm, rt);
            checkOutput("ex_ra", rf_ra, rs);
            checkOutput("ex_rb", rf_rb, rt);
            checkOutput("ex_we", rf_we, 0);
            tick();
            checkOutput("wb_we", rf_we, 1);
            checkOutput("wb_wa", rf_wa, rd);
            checkOutput("wb_aluop", alu_op, expAluOp(op));
            checkOutput("wb_ra", rf_ra, rs);
            if (abort_wb) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                start = 1'b0;
                aborted   = 1'b1;
                m_pc      = 8'd0;
                m_illegal = 1'b0;
                m_halted  = 1'b0;
                checkOutput("abort_we", rf_we, 0);
                checkOutput("abort_req", instr_req, 0);
                checkOutput("abort_addr", instr_addr, 0);
            end else begin
                tick();
                m_pc = m_pc + 8'd1;
            end
        end

        instr_valid = 1'b0;
        checkOutput("post_illegal", illegal, m_illegal);
        checkOutput("post_halted", halted, m_halted);
        checkOutput("post_we", rf_we, 0);
        if (!aborted) begin
            if (m_halted) begin
                checkOutput("post_req_h", instr_req, 0);
            end else begin
                checkOutput("post_req", instr_req, 1);
                checkOutput("post_addr", instr_addr, m_pc);
            end
        end
    endtask

    // Jumps to an absolute pc with a taken BEQZ.
    task automatic gotoPc(input logic [7:0] target);
        logic [7:0] off;
        off = target - m_pc - 8'd1;
        applyStimulus({4'h7, off[7:4], 4'h0, off[3:0]}, 0, 1'b1, 1'b0);
        checkOutput("goto_addr", instr_addr, target);
    endtask

    initial begin
        logic [15:0] w;
        reset       = 1'b1;
        start       = 1'b1;
        instr_valid = 1'b0;
        instr_data  = 16'h0000;
        alu_zero    = 1'b0;
        m_pc        = 8'd0;
        m_illegal   = 1'b0;
        m_halted    = 1'b0;

        // Reset held for two cycles with start high.
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("rst_req", instr_req, 0);
            checkOutput("rst_addr", instr_addr, 0);
            checkOutput("rst_we", rf_we, 0);
            checkOutput("rst_ra", rf_ra, 0);
            checkOutput("rst_aluop", alu_op, 0);
            checkOutput("rst_halted", halted, 0);
            checkOutput("rst_illegal", illegal, 0);
        end
        reset = 1'b0;
        tick();
        start = 1'b0;
        checkOutput("start_req", instr_req, 1);
        checkOutput("start_addr", instr_addr, 0);

        // Directed ALU, immediate and stall cases.
        applyStimulus(16'h1312, 0, 1'b0, 1'b0);
        checkOutput("after_add_addr", instr_addr, 8'd1);
        applyStimulus(16'h6545, 0, 1'b0, 1'b0);
        applyStimulus(16'h2123, 3, 1'b0, 1'b0);

        // Branch backward (taken), fall-through, and wrap at the top of pc.
        gotoPc(8'h10);
        applyStimulus(16'h7F4E, 0, 1'b1, 1'b0);
        checkOutput("br_back_addr", instr_addr, 8'h0F);
        gotoPc(8'h10);
        applyStimulus(16'h7F4E, 1, 1'b0, 1'b0);
        checkOutput("br_fall_addr", instr_addr, 8'h11);
        gotoPc(8'hFF);
        applyStimulus(16'h7001, 0, 1'b1, 1'b0);
        checkOutput("br_wrap_addr", instr_addr, 8'h01);

        // Randomized instruction stream; HALT is kept out until the end.
        for (int n = 0; n < 80; n++) begin
            w = 16'($urandom);
            if (w[15:12] == 4'hF) w[15:12] = 4'h0;
            applyStimulus(w, int'($urandom_range(0, 2)), 1'($urandom), 1'b0);
        end

        // Reset in the middle of a write-back, with illegal already set.
        applyStimulus(16'h9000, 0, 1'b0, 1'b0);
        checkOutput("illegal_set", illegal, 1);
        applyStimulus(16'h1ABC, 0, 1'b0, 1'b1);
        tick();
        checkOutput("idle_req", instr_req, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("restart_req", instr_req, 1);
        checkOutput("restart_addr", instr_addr, 0);

        // Illegal opcode, then HALT; start pulses must not revive it.
        applyStimulus(16'h9000, 0, 1'b0, 1'b0);
        checkOutput("illegal_addr", instr_addr, 8'd1);
        applyStimulus(16'hF000, 0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            start       = 1'(i % 2);
            instr_valid = 1'($urandom);
            tick();
            checkOutput("halt_halted", halted, 1);
            checkOutput("halt_req", instr_req, 0);
            checkOutput("halt_we", rf_we, 0);
            checkOutput("halt_illegal", illegal, 1);
        end
        start       = 1'b0;
        instr_valid = 1'b0;
        reset       = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("clr_halted", halted, 0);
        checkOutput("clr_illegal", illegal, 0);
        checkOutput("clr_req", instr_req, 0);
        checkOutput("clr_addr", instr_addr, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
